button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Upstream input stage for the dice/traffic-light multiplexer. Conditions the raw, asynchronous
//  push-button into a clean level ('button') that drives the multiplexer's button input.
//  Also provides single-cycle press, release and long-press event pulses.
//  Internals: 2-flop synchroniser, debounce counter, hold counter and a 4-state FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable synchronised samples needed to accept a level change (>=2)
//  LONG_CYCLES      16  cycles in PRESSED with input held high before long_press fires (>=1)
//  CNT_W            5   width of internal counters; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES)
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  asynchronous, active-high reset
//  button_raw  in   1  raw push-button; asynchronous and may bounce
//  button      out  1  debounced level; registered; feeds the multiplexer 'button' input
//  press       out  1  1-cycle pulse, coincident with button 0->1
//  release     out  1  1-cycle pulse, coincident with button 1->0
//  long_press  out  1  1-cycle pulse, at most once per accepted press
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - state=IDLE; sync flops, counters, button, press, release and long_press all 0 immediately.
//  - Synchroniser: q1<=button_raw, q2<=q1; 'sync'=q2. The FSM sees only 'sync'.
//  - States: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. cnt = debounce counter; hold = long counter.
//  - IDLE:
//    - sync=1 -> PRESS_WAIT, cnt=1.
//    - Otherwise stay.
//  - PRESS_WAIT:
//    - sync=0 -> IDLE, cnt=0. A bounce restarts qualification.
//    - sync=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1.
//    - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; button<=1, press<=1, hold=0, cnt=0.
//  - PRESSED:
//    - sync=1: hold saturates at LONG_CYCLES. On the edge where hold goes LONG_CYCLES-1 -> LONG_CYCLES, long_press<=1.
//    - sync=0 -> RELEASE_WAIT, cnt=1. hold is retained.
//  - RELEASE_WAIT:
//    - sync=1 -> PRESSED, cnt=0. button stays 1, no pulses; hold continues from its retained value.
//    - sync=0 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1.
//    - sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; button<=0, release<=1, hold=0.
//  - Pulse outputs are high for exactly one cycle, then cleared. They never overlap each other.
//  - Latency:
//    - button rises on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples button_raw=1 as the 1st.
//    - button falls with the same latency after the input goes low.
//  - Counters never wrap: cnt is bounded by DEBOUNCE_CYCLES-1, hold saturates.
//  - Reset mid-operation:
//    - Everything clears at once; no release pulse is generated.
//    - If button_raw is still high after reset deasserts, the full debounce repeats and press fires again.
//  - Bounce shorter than DEBOUNCE_CYCLES samples never changes button and generates no pulse.
// TESTING (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, clk period 10)
//  1 Reset: rst=1 with button_raw=1 -> button=press=release=long_press=0 immediately; held while rst=1.
//  2 Clean press: button_raw 0->1, held.
//    -> button=1 and press=1 on the 6th edge after button_raw is first sampled high.
//    -> press=0 on the next edge.
//  3 Bounce: button_raw pattern 1,1,0,1,1,1,1 (one value per cycle).
//    -> exactly one press pulse, issued after the last four 1s.
//    -> button never toggles before that.
//  4 Long hold: hold button_raw=1 for 30 cycles after button=1.
//    -> single long_press pulse 16 cycles after PRESSED is entered; no second pulse.
//  5 Release with glitch: low 2 cycles, high 1 cycle, then low.
//    -> button stays 1 through the glitch.
//    -> release pulse and button=0 after 4 consecutive synchronised lows.
//  6 Reset mid-press: assert rst while button=1, release rst with button_raw=1.
//    -> button=0 at once, no release pulse; press fires again 6 edges after reset deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button input stage: 2-flop synchroniser, debounce FSM, and press/release/long-press pulses.
// Ports: clk, rst (async, active-high), button_raw in; button level, press/release_pulse/long_press out.
//
// Outputs
//   button        debounced level; registered
//   press         1-cycle pulse when button goes 0->1
//   release_pulse 1-cycle pulse when button goes 1->0
//                 ('release' is a reserved word)
//   long_press    1-cycle pulse, at most once per accepted press
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hold, hold_n;
  logic             button_n, press_n, release_n, long_n;
  logic             q1, q2, sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= button_raw;
      q2 <= q1;
    end
  end

  assign sync = q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      button        <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      hold          <= hold_n;
      button        <= button_n;
      press         <= press_n;
      release_pulse <= release_n;
      long_press    <= long_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hold_n    = hold;
    button_n  = button;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (sync) begin
          state_n = PRESS_WAIT;
          cnt_n   = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n  = PRESSED;
          button_n = 1'b1;
          press_n  = 1'b1;
          hold_n   = '0;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      PRESSED: begin
        if (sync) begin
          // hold saturates, so the 15->16 step occurs once
          if (hold != LONG_MAX) begin
            hold_n = hold + ONE;
          end
          if (hold == LONG_PRE) begin
            long_n = 1'b1;
          end
        end else begin
          state_n = RELEASE_WAIT;
          cnt_n   = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n   = IDLE;
          button_n  = 1'b0;
          release_n = 1'b1;
          hold_n    = '0;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
